// File: rtl/fifo_rd_adapter_pkg.sv
// Shared defaults and types for the FIFO read-side stream adapter.
package fifo_rd_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;
  localparam int BUF_DEPTH  = 2;
  typedef logic [DATA_W_DEF-1:0] word_t;
endpackage

// File: rtl/fifo_rd_adapter_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for the adapter.
interface fifo_rd_adapter_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              fifo_empty;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_dout;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [CNT_W-1:0]  pop_cnt;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd, m_valid, m_data, pop_cnt
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd, m_valid, m_data, pop_cnt
  );
endinterface

// File: rtl/fifo_rd_adapter_skid_buf2.sv
// Two-entry ring buffer: write at tail, read at head, occupancy 0..2.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        occ_o
);
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic              head_q, tail_q;
  logic [1:0]        occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({wr_en_i, rd_en_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (wr_en_i) begin
        mem_q[tail_q] <= wdata_i;
        tail_q        <= ~tail_q;
      end
      if (rd_en_i) head_q <= ~head_q;
      occ_q <= occ_d;
    end
  end

  assign rdata_o = mem_q[head_q];
  assign occ_o   = occ_q;
endmodule

// File: rtl/fifo_rd_adapter.sv
// Turns the FIFO's rd/data_out/empty port into a valid/ready stream,
// covering the one-cycle read latency with a 2-entry skid buffer.
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  fifo_rd_adapter_if.master   bus
);
  logic              inflight_q;
  logic [CNT_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [1:0]        occ;
  logic [DATA_W-1:0] rdata;
  logic              pop, rd;
  logic [2:0]        credit;

  assign pop = bus.m_valid && bus.m_ready;

  // Slots committed after this edge: pop implies occ>=1, so no underflow.
  // Gating with rst keeps the strobe low for the whole reset window.
  assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd     = rst && !bus.fifo_empty && (credit < 3'd2);

  assign pop_cnt_d = pop ? pop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : pop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
      pop_cnt_q  <= '0;
    end else begin
      inflight_q <= rd;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

  skid_buf2 #(.DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en_i (inflight_q),
    .wdata_i (bus.fifo_dout),
    .rd_en_i (pop),
    .rdata_o (rdata),
    .occ_o   (occ)
  );

  assign bus.fifo_rd = rd;
  assign bus.m_valid = (occ != 2'd0);
  assign bus.m_data  = rdata;
  assign bus.pop_cnt = pop_cnt_q;
endmodule
